// File: rtl/tx_handoff_pkg.sv
// Shared types and default sizing for the REF_CLK-side TX byte handoff queue.
//   tx_state_e     : handoff sequencer states
//   DEF_*          : default parameter values used by tx_handoff_queue
package tx_handoff_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_FIFO_DEPTH     = 8;
  localparam int unsigned DEF_ADDR_WIDTH     = 3;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

endpackage : tx_handoff_pkg

// File: rtl/tx_handoff_queue_sync_fifo.sv
// Small synchronous FIFO; head entry is visible combinationally on rd_data.
//   REF_CLK, RST_REF : clock, async active-low reset
//   wr_en, wr_data   : push (ignored while full)
//   rd_en, rd_data   : pop (ignored while empty), head of queue
//   full, empty      : occupancy flags
//   count            : current occupancy, 0..FIFO_DEPTH
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  REF_CLK,
  input  logic                  RST_REF,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_ok && !rd_ok)      count <= count + CW'(1);
      else if (rd_ok && !wr_ok) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; contents are only read behind a valid count.
  always_ff @(posedge REF_CLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule : sync_fifo

// File: rtl/tx_handoff_queue.sv
// Queues controller TX bytes and hands them one at a time to the REF->TX
// synchronizer as a level-held data/valid pair, paced by the TX busy flag.
//   REF_CLK, RST_REF : clock, async active-low reset
//   in_data/in_valid : byte + single-cycle push strobe from controller
//   in_ready         : queue not full (combinational)
//   tx_busy_sync     : transmitter busy, already in REF_CLK domain
//   tx_data/tx_valid : registered byte/level valid to synchronizer
//   fifo_count       : queue occupancy
//   overflow         : sticky, push attempted while full
//   tx_timeout       : sticky, busy never rose for a presented byte
module tx_handoff_queue
  import tx_handoff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  REF_CLK,
  input  logic                  RST_REF,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  tx_busy_sync,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  tx_timeout
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_seen_q, busy_seen_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_timeout_q, tx_timeout_d;
  logic                  overflow_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push;
  logic                  pop;

  // Room is judged before any same-cycle pop.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .REF_CLK (REF_CLK),
    .RST_REF (RST_REF),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Handoff sequencer state and output registers.
  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_seen_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_seen_q  <= busy_seen_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  // Next-state logic: present, hold, then wait for busy to rise and fall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_seen_d  = busy_seen_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_timeout_d = tx_timeout_q;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy_sync) begin
          pop         = 1'b1;
          tx_data_d   = fifo_head;
          tx_valid_d  = 1'b1;
          cnt_d       = '0;
          busy_seen_d = 1'b0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        busy_seen_d = busy_seen_q || tx_busy_sync;
        if (cnt_q == HOLD_LAST) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = (busy_seen_q || tx_busy_sync) ? WAIT_LO : WAIT_HI;
        end
      end
      WAIT_HI: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (tx_busy_sync) begin
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Transmitter never took the byte; drop it and move on.
          cnt_d        = '0;
          tx_timeout_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow on any push attempt against a full queue.
  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF)                  overflow_q <= 1'b0;
    else if (in_valid && fifo_full) overflow_q <= 1'b1;
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_timeout = tx_timeout_q;
  assign overflow   = overflow_q;

endmodule : tx_handoff_queue

// File: tb/tb_tx_handoff_queue.sv
// Directed self-checking bench for tx_handoff_queue.
module tb_tx_handoff_queue;

  logic       REF_CLK;
  logic       RST_REF;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_busy_sync;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       tx_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  tx_handoff_queue dut (
    .REF_CLK      (REF_CLK),
    .RST_REF      (RST_REF),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tx_busy_sync (tx_busy_sync),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .tx_timeout   (tx_timeout)
  );

  initial REF_CLK = 1'b0;
  always #5 REF_CLK = ~REF_CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge REF_CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a presented byte, check it and its 16-cycle hold; optionally
  // raise busy in hold cycle 5 and keep it for busy_len cycles after hold.
  task automatic expect_byte(input string tag, input logic [7:0] exp, input bit raise_busy,
                             input int busy_len);
    int waited;
    int hi;
    int bad;
    int spurious;
    waited = 0;
    while (!tx_valid && waited < 60) begin
      tick();
      waited++;
    end
    check_eq({tag, "_valid_seen"}, 32'(tx_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(tx_data), 32'(exp));
    hi  = 0;
    bad = 0;
    while (tx_valid && hi < 40) begin
      if (tx_data !== exp) bad++;
      if (raise_busy && hi == 4) tx_busy_sync = 1'b1;
      hi++;
      tick();
    end
    check_eq({tag, "_hold_len"}, 32'(hi), 32'd16);
    check_eq({tag, "_data_stable"}, 32'(bad), 32'd0);
    if (raise_busy) begin
      spurious = 0;
      for (int i = 0; i < busy_len; i++) begin
        tick();
        if (tx_valid) spurious++;
      end
      check_eq({tag, "_no_valid_busy"}, 32'(spurious), 32'd0);
      check_eq({tag, "_data_kept"}, 32'(tx_data), 32'(exp));
      tx_busy_sync = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    RST_REF      = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    tx_busy_sync = 1'b0;
    tick();
    tick();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_timeout", 32'(tx_timeout), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    RST_REF = 1'b1;
    tick();

    // 1: single byte, busy rises in hold, falls 40 cycles later
    push_byte(8'hA5);
    check_eq("t1_count_after_push", 32'(fifo_count), 32'd1);
    check_eq("t1_no_fallthrough", 32'(tx_valid), 32'd0);
    tick();
    check_eq("t1_valid", 32'(tx_valid), 32'd1);
    check_eq("t1_count_after_pop", 32'(fifo_count), 32'd0);
    expect_byte("t1", 8'hA5, 1'b1, 40);
    tick();
    check_eq("t1_idle_no_valid", 32'(tx_valid), 32'd0);

    // 2: two bytes back-to-back, in order, gap between them
    push_byte(8'h34);
    push_byte(8'h12);
    check_eq("t2_count", 32'(fifo_count), 32'd1);
    expect_byte("t2a", 8'h34, 1'b1, 6);
    check_eq("t2_gap_low", 32'(tx_valid), 32'd0);
    expect_byte("t2b", 8'h12, 1'b1, 6);

    // 3: fill while busy, overflow on the ninth push, drain in order
    tx_busy_sync = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_byte(8'(i));
      if (i == 7) begin
        check_eq("t3_ready_full", 32'(in_ready), 32'd0);
        check_eq("t3_no_ovf_yet", 32'(overflow), 32'd0);
      end
    end
    check_eq("t3_overflow", 32'(overflow), 32'd1);
    check_eq("t3_count_full", 32'(fifo_count), 32'd8);
    check_eq("t3_idle_while_busy", 32'(tx_valid), 32'd0);
    tx_busy_sync = 1'b0;
    for (int i = 0; i < 8; i++) expect_byte("t3", 8'(i), 1'b1, 2);
    check_eq("t3_drained", 32'(fifo_count), 32'd0);
    check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: busy never rises -> timeout after 255 WAIT_HI cycles
    push_byte(8'h5A);
    push_byte(8'h6B);
    expect_byte("t4a", 8'h5A, 1'b0, 0);
    check_eq("t4_no_timeout_yet", 32'(tx_timeout), 32'd0);
    n = 0;
    while (!tx_timeout && n < 300) begin
      tick();
      n++;
    end
    check_eq("t4_timeout_cycles", 32'(n), 32'd255);
    check_eq("t4_timeout", 32'(tx_timeout), 32'd1);
    tick();
    check_eq("t4_next_valid", 32'(tx_valid), 32'd1);
    expect_byte("t4b", 8'h6B, 1'b1, 3);
    check_eq("t4_timeout_sticky", 32'(tx_timeout), 32'd1);

    // 5: reset in hold cycle 7 clears everything at once
    push_byte(8'h77);
    push_byte(8'h78);
    check_eq("t5_valid", 32'(tx_valid), 32'd1);
    repeat (6) tick();
    #2;
    RST_REF = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(tx_valid), 32'd0);
    check_eq("t5_rst_count", 32'(fifo_count), 32'd0);
    check_eq("t5_rst_overflow", 32'(overflow), 32'd0);
    check_eq("t5_rst_timeout", 32'(tx_timeout), 32'd0);
    check_eq("t5_rst_ready", 32'(in_ready), 32'd1);
    #2;
    RST_REF = 1'b1;
    tick();
    tick();
    check_eq("t5_idle_after", 32'(tx_valid), 32'd0);

    // 6: busy before push holds the byte in IDLE until busy falls
    tx_busy_sync = 1'b1;
    push_byte(8'hC3);
    repeat (5) tick();
    check_eq("t6_held_valid", 32'(tx_valid), 32'd0);
    check_eq("t6_held_count", 32'(fifo_count), 32'd1);
    tx_busy_sync = 1'b0;
    tick();
    check_eq("t6_valid_next_edge", 32'(tx_valid), 32'd1);
    expect_byte("t6", 8'hC3, 1'b1, 3);
    check_eq("t6_empty", 32'(fifo_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tx_handoff_queue
